// File: rtl/gx_rst_pkg.sv
// Shared state encoding and default timing for the transceiver reset sequencer.
// Timing defaults are in reference-clock cycles.
package gx_rst_pkg;

  typedef enum logic [2:0] {
    ST_PWRDN    = 3'd0,
    ST_WAIT_PLL = 3'd1,
    ST_TX_REL   = 3'd2,
    ST_RX_ANA   = 3'd3,
    ST_RX_DIG   = 3'd4,
    ST_RUN      = 3'd5
  } gx_state_e;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_T_PWRDN  = 200;
  localparam int DEF_T_PLL_TO = 4000;
  localparam int DEF_T_LTD    = 2500;
  localparam int DEF_T_RXDIG  = 200;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/gx_rst_seq_if.sv
// Status inputs and reset outputs of the sequencer; master is the sequencer side.
// NUM_CH must match the sequencer's NUM_CH.
interface gx_rst_seq_if #(
  parameter int NUM_CH = 4
);
  logic              gxb_pwrdn_in;
  logic              pll_locked;
  logic              reconfig_busy;
  logic [NUM_CH-1:0] rx_freqlocked;
  logic              gxb_powerdown;
  logic              pll_areset;
  logic              tx_digitalreset;
  logic              rx_analogreset;
  logic [NUM_CH-1:0] rx_digitalreset;
  logic              ready;
  logic [2:0]        state_o;

  modport master (
    input  gxb_pwrdn_in, pll_locked, reconfig_busy, rx_freqlocked,
    output gxb_powerdown, pll_areset, tx_digitalreset, rx_analogreset,
    output rx_digitalreset, ready, state_o
  );

  modport slave (
    output gxb_pwrdn_in, pll_locked, reconfig_busy, rx_freqlocked,
    input  gxb_powerdown, pll_areset, tx_digitalreset, rx_analogreset,
    input  rx_digitalreset, ready, state_o
  );
endinterface

// File: rtl/gx_rst_ch_lock.sv
// Per-channel CDR lock qualifier: releases rx_digitalreset after T_RXDIG stable lock cycles.
// 2-cycle synchronizer latency; any lock drop or en low reasserts reset on the next edge.
module gx_rst_ch_lock #(
  parameter int T_RXDIG = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic freqlocked,
  output logic rst_d,
  output logic rst_q
);

  localparam int CW = $clog2(T_RXDIG + 1);

  logic          meta_q;
  logic          lock_s;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // rst_d is exported so the parent can register ready in step with rst_q
  always_comb begin
    cnt_d = '0;
    if (en && lock_s) begin
      cnt_d = (cnt_q == CW'(T_RXDIG)) ? cnt_q : cnt_q + 1'b1;
    end
    rst_d = (cnt_d != CW'(T_RXDIG));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      lock_s <= 1'b0;
      cnt_q  <= '0;
      rst_q  <= 1'b1;
    end else begin
      meta_q <= freqlocked;
      lock_s <= meta_q;
      cnt_q  <= cnt_d;
      rst_q  <= rst_d;
    end
  end

endmodule

// File: rtl/gx_rst_seq.sv
// Transceiver reset sequencer: powerdown, PLL lock, TX release, RX analog then per-channel RX digital release.
// Inputs see 2-cycle synchronizer latency; all outputs registered, updated on the edge the FSM changes state.
module gx_rst_seq
  import gx_rst_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int T_PWRDN  = DEF_T_PWRDN,
  parameter int T_PLL_TO = DEF_T_PLL_TO,
  parameter int T_LTD    = DEF_T_LTD,
  parameter int T_RXDIG  = DEF_T_RXDIG
) (
  input  logic         clk,
  input  logic         rst_n,
  gx_rst_seq_if.master gx
);

  localparam int TW = $clog2(max3(T_PWRDN, T_PLL_TO, T_LTD)) + 1;

  logic [2:0]        meta_q;
  logic [2:0]        sync_q;
  logic              pwrdn_s;
  logic              pll_s;
  logic              busy_s;
  gx_state_e         state_q;
  gx_state_e         state_d;
  logic [TW-1:0]     timer_q;
  logic [TW-1:0]     timer_d;
  logic              ch_en;
  logic [NUM_CH-1:0] rxd_d;
  logic [NUM_CH-1:0] rxd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {gx.gxb_pwrdn_in, gx.pll_locked, gx.reconfig_busy};
      sync_q <= meta_q;
    end
  end

  assign pwrdn_s = sync_q[2];
  assign pll_s   = sync_q[1];
  assign busy_s  = sync_q[0];

  always_comb begin
    state_d = ST_PWRDN;
    case (state_q)
      ST_PWRDN:    state_d = (timer_q == TW'(T_PWRDN - 1)) ? ST_WAIT_PLL : ST_PWRDN;
      ST_WAIT_PLL: begin
        if (pll_s)                               state_d = ST_TX_REL;
        else if (timer_q == TW'(T_PLL_TO - 1))   state_d = ST_PWRDN;
        else                                     state_d = ST_WAIT_PLL;
      end
      ST_TX_REL:   state_d = busy_s ? ST_TX_REL : ST_RX_ANA;
      ST_RX_ANA:   state_d = (timer_q == TW'(T_LTD - 1)) ? ST_RX_DIG : ST_RX_ANA;
      ST_RX_DIG:   state_d = (rxd_q == '0) ? ST_RUN : ST_RX_DIG;
      ST_RUN:      state_d = ST_RUN;
      default:     state_d = ST_PWRDN;
    endcase
    if (!pll_s && (state_q inside {ST_TX_REL, ST_RX_ANA, ST_RX_DIG, ST_RUN})) begin
      state_d = ST_WAIT_PLL;
    end
    // Powerdown request wins over everything, including lock loss
    if (pwrdn_s) begin
      state_d = ST_PWRDN;
    end
  end

  // Held at zero while powerdown is requested so T_PWRDN counts from its release
  always_comb begin
    timer_d = timer_q;
    if ((state_d != state_q) || pwrdn_s) begin
      timer_d = '0;
    end else if (timer_q != '1) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PWRDN;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  assign ch_en = (state_d == ST_RX_DIG) || (state_d == ST_RUN);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    gx_rst_ch_lock #(
      .T_RXDIG (T_RXDIG)
    ) u_ch_lock (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (ch_en),
      .freqlocked (gx.rx_freqlocked[i]),
      .rst_d      (rxd_d[i]),
      .rst_q      (rxd_q[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx.gxb_powerdown   <= 1'b1;
      gx.pll_areset      <= 1'b1;
      gx.tx_digitalreset <= 1'b1;
      gx.rx_analogreset  <= 1'b1;
      gx.ready           <= 1'b0;
    end else begin
      gx.gxb_powerdown   <= (state_d == ST_PWRDN);
      gx.pll_areset      <= (state_d == ST_PWRDN);
      gx.tx_digitalreset <= !(state_d inside {ST_TX_REL, ST_RX_ANA, ST_RX_DIG, ST_RUN});
      gx.rx_analogreset  <= !(state_d inside {ST_RX_ANA, ST_RX_DIG, ST_RUN});
      gx.ready           <= (state_d == ST_RUN) && (rxd_d == '0);
    end
  end

  assign gx.rx_digitalreset = rxd_q;
  assign gx.state_o         = state_q;

endmodule
